// File: rtl/sequence_detector_pkg.sv
// -----------------------------------------------------------------------------
// sequence_detector_pkg
// Shared definitions for the "101" serial pattern detector: the 2-bit state
// type and the fixed state encodings. Every 2-bit code is a legal state.
// -----------------------------------------------------------------------------
package sequence_detector_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S0 = 2'b00;  // idle, no useful prefix seen
    localparam state_t S1 = 2'b01;  // saw "1"
    localparam state_t S2 = 2'b10;  // saw "10"
    localparam state_t S3 = 2'b11;  // saw "101" (detect state)

endpackage : sequence_detector_pkg

// File: rtl/sequence_detector.sv
// -----------------------------------------------------------------------------
// sequence_detector
// Moore FSM that detects the serial pattern 1,0,1 on seq_in with overlap
// allowed. The detect flag is decoded from the state register only, so it
// rises in the cycle after the edge that samples the final "1" and lasts one
// cycle per detection.
//
// Ports
//   clock  : in  1  single clock, all state changes on its rising edge
//   reset  : in  1  synchronous active-high reset, forces state to S0
//   seq_in : in  1  serial data bit, sampled on each rising edge
//   det_o  : out 1  high exactly while state == S3
//
// The 2-bit register `state` is the FSM state; it is kept at this level so
// it can be probed hierarchically.
// -----------------------------------------------------------------------------
module sequence_detector
    import sequence_detector_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic seq_in,
    output logic det_o
);

    state_t state;
    state_t next_state;

    // State register; reset overrides every transition, including from S3.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S0;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = S0;
        case (state)
            S0: next_state = seq_in ? S1 : S0;
            S1: next_state = seq_in ? S1 : S2;
            S2: next_state = seq_in ? S3 : S0;
            // The trailing "1" of a detection is reused as a new prefix,
            // and "1010" already holds "10", so both branches keep progress.
            S3: next_state = seq_in ? S1 : S2;
            default: next_state = S0;
        endcase
    end

    // Moore output: no path from seq_in.
    assign det_o = (state == S3);

endmodule : sequence_detector

// File: tb/tb_sequence_detector.sv
// -----------------------------------------------------------------------------
// tb_sequence_detector
// Directed bench for sequence_detector. Inputs are applied 1 time unit after
// a rising edge; outputs and the internal state are sampled 1 time unit after
// the following rising edge. Expected values are hand-derived from the state
// table.
// -----------------------------------------------------------------------------
module tb_sequence_detector;

    logic clock;
    logic reset;
    logic seq_in;
    logic det_o;

    int checks;
    int errors;

    sequence_detector dut (
        .clock  (clock),
        .reset  (reset),
        .seq_in (seq_in),
        .det_o  (det_o)
    );

    // Clock generation.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Compare state and det_o, and confirm det_o is only ever high in S3.
    task automatic check(input string tag, input logic [1:0] exp_state,
                         input logic exp_det);
        checks++;
        assert (dut.state === exp_state) else begin
            errors++;
            $error("FAIL %s state observed=%b expected=%b", tag, dut.state, exp_state);
        end
        checks++;
        assert (det_o === exp_det) else begin
            errors++;
            $error("FAIL %s det_o observed=%b expected=%b", tag, det_o, exp_det);
        end
        checks++;
        assert (det_o !== 1'b1 || dut.state === 2'b11) else begin
            errors++;
            $error("FAIL %s det_in_non_s3 det_o=%b state=%b expected state=11",
                   tag, det_o, dut.state);
        end
    endtask

    // One clock edge with the given serial bit, then check.
    task automatic step(input string tag, input logic b,
                        input logic [1:0] exp_state, input logic exp_det);
        seq_in = b;
        @(posedge clock);
        #1;
        check(tag, exp_state, exp_det);
    endtask

    // One edge with reset high and the given serial bit.
    task automatic do_reset(input string tag, input logic b);
        reset  = 1'b1;
        seq_in = b;
        @(posedge clock);
        #1;
        check(tag, 2'b00, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        seq_in = 1'b0;
        #1;

        // Reset state.
        do_reset("reset_init", 1'b0);
        do_reset("reset_hold_in1", 1'b1);

        // 0,1,0,1,0,1,1 -> S0,S1,S2,S3,S2,S3,S1 ; det 0,0,0,1,0,1,0
        step("a0", 1'b0, 2'b00, 1'b0);
        step("a1", 1'b1, 2'b01, 1'b0);
        step("a2", 1'b0, 2'b10, 1'b0);
        step("a3", 1'b1, 2'b11, 1'b1);
        step("a4", 1'b0, 2'b10, 1'b0);
        step("a5", 1'b1, 2'b11, 1'b1);
        step("a6", 1'b1, 2'b01, 1'b0);

        // Reset, then 1,0,1,1 -> S1,S2,S3,S1
        do_reset("reset_b", 1'b0);
        step("b0", 1'b1, 2'b01, 1'b0);
        step("b1", 1'b0, 2'b10, 1'b0);
        step("b2", 1'b1, 2'b11, 1'b1);
        step("b3", 1'b1, 2'b01, 1'b0);

        // Reset, then 1,1,0,1 -> S1,S1,S2,S3
        do_reset("reset_c", 1'b1);
        step("c0", 1'b1, 2'b01, 1'b0);
        step("c1", 1'b1, 2'b01, 1'b0);
        step("c2", 1'b0, 2'b10, 1'b0);
        step("c3", 1'b1, 2'b11, 1'b1);

        // From S3: 1,0,0,1 -> S1,S2,S0,S1, no detection
        step("d0", 1'b1, 2'b01, 1'b0);
        step("d1", 1'b0, 2'b10, 1'b0);
        step("d2", 1'b0, 2'b00, 1'b0);
        step("d3", 1'b1, 2'b01, 1'b0);

        // S1 -> S2, then reset mid-pattern with seq_in=1
        step("e0", 1'b0, 2'b10, 1'b0);
        do_reset("reset_in_s2", 1'b1);
        step("e1", 1'b1, 2'b01, 1'b0);
        step("e2", 1'b0, 2'b10, 1'b0);
        step("e3", 1'b1, 2'b11, 1'b1);
        step("e4", 1'b0, 2'b10, 1'b0);

        // Reach S3, then reset while detecting
        step("f0", 1'b1, 2'b11, 1'b1);
        do_reset("reset_in_s3", 1'b1);
        step("f1", 1'b0, 2'b00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sequence_detector
